// File: rtl/qmf_subband_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : qmf_subband_decimator
//  Description : Decimates the QMF low/high subband streams by 2 (selectable
//                polyphase), packs each retained pair into one word and
//                buffers it in a first-word-fall-through FIFO with frame
//                markers. Losses are reported, the upstream is never stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module qmf_subband_decimator #(
    parameter int DATAW     = 16,
    parameter int DEPTH     = 8,
    parameter int PHASE     = 0,
    parameter int FRAME_LEN = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [DATAW-1:0]           din_low,
    input  logic [DATAW-1:0]           din_high,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [2*DATAW-1:0]         m_data,
    output logic                       m_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH + 1);
    localparam int c_FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int c_WW = 2 * DATAW + 1;

    // Storage word: {last tag, high sample, low sample}
    logic [c_WW-1:0] mem_q [DEPTH];

    logic            phase_q,     phase_d;
    logic [c_AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [c_LW-1:0] level_q,     level_d;
    logic [c_FW-1:0] frame_cnt_q, frame_cnt_d;
    logic            overflow_q,  overflow_d;
    logic [15:0]     drop_cnt_q,  drop_cnt_d;

    logic            retain;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            tag;
    logic [c_WW-1:0] head;

    // Next-state: decimation select, FIFO bookkeeping, framing and loss stats
    always_comb begin
        retain = in_valid && (phase_q == 1'(PHASE));
        full   = (level_q == c_LW'(DEPTH));
        pop    = (level_q != '0) && m_ready;
        // A full FIFO still accepts when the head leaves in the same cycle
        push   = retain && (!full || pop);
        drop   = retain && !push;
        tag    = (frame_cnt_q == c_FW'(FRAME_LEN - 1));

        phase_d     = phase_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (in_valid) begin
            phase_d = ~phase_q;
        end
        if (push) begin
            wr_ptr_d    = wr_ptr_q + c_AW'(1);
            frame_cnt_d = tag ? '0 : frame_cnt_q + c_FW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + c_LW'(1);
            2'b01:   level_d = level_q - c_LW'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end

        // Flush wins over any push/pop in the same cycle
        if (clear) begin
            phase_d     = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            frame_cnt_d = '0;
            overflow_d  = 1'b0;
            drop_cnt_d  = '0;
        end
    end

    // Control/state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Data array needs no reset: entries are only visible once counted in level
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= {tag, din_high, din_low};
        end
    end

    // Fall-through head; data forced to zero while empty so reset shows zeros
    always_comb begin
        head     = mem_q[rd_ptr_q];
        m_valid  = (level_q != '0);
        m_data   = m_valid ? head[2*DATAW-1:0] : '0;
        m_last   = m_valid && head[c_WW-1];
        level    = level_q;
        overflow = overflow_q;
        drop_cnt = drop_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_qmf_subband_decimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qmf_subband_decimator
//  Description : Directed bench for qmf_subband_decimator; one instance per
//                polyphase (both DEPTH=8, FRAME_LEN=4) sharing the stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qmf_subband_decimator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] din_low = '0;
    logic [15:0] din_high = '0;
    logic        m_ready = 1'b0;

    logic        m_valid0, m_last0, overflow0;
    logic [31:0] m_data0;
    logic [3:0]  level0;
    logic [15:0] drop_cnt0;
    logic        m_valid1, m_last1, overflow1;
    logic [31:0] m_data1;
    logic [3:0]  level1;
    logic [15:0] drop_cnt1;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    qmf_subband_decimator #(.DATAW(16), .DEPTH(8), .PHASE(0), .FRAME_LEN(4)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .din_low(din_low), .din_high(din_high), .m_valid(m_valid0),
        .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
        .level(level0), .overflow(overflow0), .drop_cnt(drop_cnt0)
    );

    qmf_subband_decimator #(.DATAW(16), .DEPTH(8), .PHASE(1), .FRAME_LEN(4)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .din_low(din_low), .din_high(din_high), .m_valid(m_valid1),
        .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1),
        .level(level1), .overflow(overflow1), .drop_cnt(drop_cnt1)
    );

    typedef struct {
        logic iv;  int lo;   logic rdy;
        logic e0v; int e0lo; logic e0last; int e0lvl;
        logic e1v; int e1lo; int e1lvl;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [31:0] pack(int v);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(v);
        hi = 16'(-v);
        return {hi, lo};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic iv, int v, logic rdy);
        in_valid = iv;
        din_low  = 16'(v);
        din_high = 16'(-v);
        m_ready  = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        //          iv lo rdy  e0v lo last lvl   e1v lo lvl
        tbl[0] = '{1'b1, 1, 1'b1, 1'b1, 1, 1'b0, 1, 1'b0, 0, 0};
        tbl[1] = '{1'b1, 2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 2, 1};
        tbl[2] = '{1'b1, 3, 1'b1, 1'b1, 3, 1'b0, 1, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1, 1'b0, 0, 0};
        tbl[4] = '{1'b1, 4, 1'b0, 1'b1, 3, 1'b0, 1, 1'b1, 4, 1};
        tbl[5] = '{1'b1, 5, 1'b0, 1'b1, 3, 1'b0, 2, 1'b1, 4, 1};
        tbl[6] = '{1'b1, 6, 1'b1, 1'b1, 5, 1'b0, 1, 1'b1, 6, 1};
        tbl[7] = '{1'b1, 7, 1'b1, 1'b1, 7, 1'b1, 1, 1'b0, 0, 0};
        tbl[8] = '{1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0};

        // Reset state
        cyc();
        chk("rst_m_valid", 32'(m_valid0), 32'd0);
        chk("rst_level",   32'(level0),   32'd0);
        chk("rst_m_data",  m_data0,       32'd0);
        chk("rst_m_last",  32'(m_last0),  32'd0);
        chk("rst_overflow", 32'(overflow0), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt0), 32'd0);
        rst = 1'b0;

        // Table: contiguous decimation, both polyphases, small framing check
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].iv, tbl[i].lo, tbl[i].rdy);
            cyc();
            chk($sformatf("tbl%0d_v0", i),   32'(m_valid0), 32'(tbl[i].e0v));
            chk($sformatf("tbl%0d_lvl0", i), 32'(level0),   32'(tbl[i].e0lvl));
            if (tbl[i].e0v) begin
                chk($sformatf("tbl%0d_data0", i), m_data0, pack(tbl[i].e0lo));
                chk($sformatf("tbl%0d_last0", i), 32'(m_last0), 32'(tbl[i].e0last));
            end
            chk($sformatf("tbl%0d_v1", i),   32'(m_valid1), 32'(tbl[i].e1v));
            chk($sformatf("tbl%0d_lvl1", i), 32'(level1),   32'(tbl[i].e1lvl));
            if (tbl[i].e1v) begin
                chk($sformatf("tbl%0d_data1", i), m_data1, pack(tbl[i].e1lo));
            end
        end

        // Gapped input: one valid every third cycle keeps the same selection
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i, 1'b1);
            cyc();
            if (i % 2 == 1) begin
                chk($sformatf("gap%0d_v0", i), 32'(m_valid0), 32'd1);
                chk($sformatf("gap%0d_d0", i), m_data0, pack(i));
                chk($sformatf("gap%0d_v1", i), 32'(m_valid1), 32'd0);
            end else begin
                chk($sformatf("gap%0d_v1", i), 32'(m_valid1), 32'd1);
                chk($sformatf("gap%0d_d1", i), m_data1, pack(i));
                chk($sformatf("gap%0d_v0", i), 32'(m_valid0), 32'd0);
            end
            drive(1'b0, 0, 1'b1);
            cyc();
            cyc();
        end

        // Overflow: 20 pairs with no consumer -> 10 retained, 8 kept, 2 dropped
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, i, 1'b0);
            cyc();
        end
        chk("ovf_level0", 32'(level0), 32'd8);
        chk("ovf_flag0",  32'(overflow0), 32'd1);
        chk("ovf_drops0", 32'(drop_cnt0), 32'd2);
        chk("ovf_level1", 32'(level1), 32'd8);
        chk("ovf_drops1", 32'(drop_cnt1), 32'd2);
        drive(1'b0, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_v", k),    32'(m_valid0), 32'd1);
            chk($sformatf("drain%0d_data", k), m_data0, pack(2 * k + 1));
            chk($sformatf("drain%0d_last", k), 32'(m_last0), 32'((k % 4) == 3));
            cyc();
        end
        chk("drain_empty", 32'(m_valid0), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow0), 32'd1);

        // Framing continues across drops: next 4 accepted words end a frame
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 21 + i, 1'b1);
            cyc();
            if (i % 2 == 0) begin
                chk($sformatf("frm%0d_data", i), m_data0, pack(21 + i));
                chk($sformatf("frm%0d_last", i), 32'(m_last0), 32'(i == 6));
            end
        end

        // Full FIFO with simultaneous push and pop: accepted, no overflow
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, i, 1'b0);
            cyc();
        end
        chk("full_level", 32'(level0), 32'd8);
        drive(1'b1, 100, 1'b1);
        cyc();
        chk("full_pp_level", 32'(level0), 32'd8);
        chk("full_pp_ovf",   32'(overflow0), 32'd0);
        drive(1'b0, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fd%0d_data", k), m_data0, (k == 7) ? pack(100) : pack(2 * k + 3));
            cyc();
        end
        chk("fd_empty", 32'(level0), 32'd0);

        // Clear with level=5 and overflow set
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, i, 1'b0);
            cyc();
        end
        drive(1'b0, 0, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("pre_clr_level", 32'(level0), 32'd5);
        chk("pre_clr_ovf",   32'(overflow0), 32'd1);
        clear = 1'b1;
        drive(1'b1, 99, 1'b1);
        cyc();
        clear = 1'b0;
        chk("clr_level",  32'(level0), 32'd0);
        chk("clr_valid",  32'(m_valid0), 32'd0);
        chk("clr_ovf",    32'(overflow0), 32'd0);
        chk("clr_drops",  32'(drop_cnt0), 32'd0);
        chk("clr_data",   m_data0, 32'd0);
        chk("clr_level1", 32'(level1), 32'd0);
        drive(1'b1, 50, 1'b0);
        cyc();
        chk("clr_phase0", m_data0, pack(50));
        chk("clr_phase1", 32'(level1), 32'd0);

        // Asynchronous reset mid-stream: outputs clear without a clock edge
        for (int i = 51; i <= 70; i++) begin
            drive(1'b1, i, 1'b0);
            cyc();
        end
        chk("pre_arst_ovf", 32'(overflow0), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level0),    32'd0);
        chk("arst_valid", 32'(m_valid0),  32'd0);
        chk("arst_ovf",   32'(overflow0), 32'd0);
        chk("arst_drops", 32'(drop_cnt0), 32'd0);
        chk("arst_data",  m_data0,        32'd0);
        chk("arst_last",  32'(m_last0),   32'd0);
        drive(1'b0, 0, 1'b0);
        cyc();
        rst = 1'b0;
        drive(1'b1, 7, 1'b0);
        cyc();
        chk("post_arst_data", m_data0, pack(7));
        chk("post_arst_last", 32'(m_last0), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qmf_subband_decimator.md
Name: qmf_subband_decimator

Overview:
- Consumes the two full-rate subband streams from the QMF analysis stage and decimates both by 2, keeping one selectable polyphase.
- Packs each retained low/high pair into a single word and buffers it in a small synchronous FIFO.
- Presents the buffered words on a valid/ready stream with frame markers for downstream subband processing or a DMA/stream bridge.
- Reports overflow; never stalls the analysis stage.

Parameters:
- DATAW, 16, subband sample width (matches the analysis stage output).
- DEPTH, 8, FIFO depth in packed words; power of 2, at least 2.
- PHASE, 0, retained polyphase (0 = first valid sample after reset/clear, 1 = second).
- FRAME_LEN, 64, accepted output words per frame; m_last marks the final word; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clear  in  1  synchronous flush of all state
- in_valid  in  1  qualifies din_low/din_high; one full-rate sample pair per asserted cycle
- din_low  in  DATAW  signed low-band sample
- din_high  in  DATAW  signed high-band sample
- m_valid  out  1  head word available
- m_ready  in  1  consumer accepts head word
- m_data  out  2*DATAW  packed pair: high in [2*DATAW-1:DATAW], low in [DATAW-1:0]
- m_last  out  1  head word is last of frame
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- overflow  out  1  sticky: a retained pair was dropped
- drop_cnt  out  16  saturating count of dropped pairs

Behaviour:
- Reset (rst=1, async) and clear (sync) have identical effect:
  - phase=0, FIFO empty, frame counter=0.
  - m_valid=0, m_last=0, m_data=0, level=0, overflow=0, drop_cnt=0.
  - Clear overrides any push or pop in the same cycle.
- Phase counter: 1 bit, toggles on every in_valid cycle. A pair is retained when in_valid=1 and phase==PHASE before the toggle. Non-retained pairs are discarded silently; they are not counted as drops.
- Push:
  - A retained pair is written if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - On write, the tag bit is set to (frame_cnt==FRAME_LEN-1). frame_cnt then increments and wraps to 0 after FRAME_LEN-1.
  - frame_cnt advances only on accepted words.
- Drop:
  - A retained pair that cannot be written is discarded.
  - overflow is set (sticky until rst/clear); drop_cnt increments, saturating at 16'hFFFF.
  - frame_cnt does not advance on a drop.
- Pop: occurs when m_valid && m_ready. The read pointer advances.
- Output is first-word-fall-through:
  - m_data and m_last reflect the head entry whenever m_valid=1.
  - m_valid = (level!=0).
  - m_data and m_last are don't-care when m_valid=0.
- Latency: a pair pushed in cycle N is visible on m_valid/m_data in cycle N+1 if the FIFO was empty.
- Occupancy:
  - Push and pop in the same cycle: level unchanged.
  - Push only: level+1. Pop only: level-1.
  - Pop with m_valid=0 is ignored.
- Pointers: log2(DEPTH) bits, wrap naturally. Full and empty are derived from level.
- No back-pressure to the upstream stage: in_valid is always accepted; losses are reported only via overflow/drop_cnt.
- Reset asserted mid-frame or mid-burst: all buffered data is lost; the next retained pair starts a new frame at frame_cnt=0.

Test Plan:
- Decimation, PHASE=0: in_valid held high, low=1,2,3,…, high=-1,-2,-3,…, m_ready=1 → m_data pairs low=1,3,5,…; high=-1,-3,-5,…; first m_valid one cycle after the first retained input.
- Decimation, PHASE=1: same stimulus → low=2,4,6,…. Gapped in_valid (every third cycle) gives the same sample selection as contiguous input.
- Overflow, DEPTH=8: m_ready=0, 20 contiguous in_valid pairs → 10 retained, level=8, overflow=1, drop_cnt=2. Then m_ready=1 → exactly the first 8 retained pairs drain in order.
- Full with simultaneous push/pop: level=8, m_ready=1 on the cycle a retained pair arrives → pair accepted, level stays 8, overflow stays 0.
- Framing, FRAME_LEN=4: 12 accepted words → m_last=1 on words 4, 8 and 12 only. With drops inserted, m_last stays on every 4th accepted word.
- Clear and reset: assert clear with level=5 and overflow=1 → next cycle level=0, m_valid=0, overflow=0, drop_cnt=0, phase reset. Assert rst asynchronously mid-stream → outputs go to reset values immediately.
